// File: rtl/rv_loader_pkg.sv
// Shared constants, error codes and FSM states for the instruction memory loader.
package rv_loader_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_IMM  = 2'b01;
  localparam logic [1:0] ERR_OPC  = 2'b10;
  localparam logic [1:0] ERR_OVF  = 2'b11;

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  // True when v is a sign extension of its low msb+1 bits.
  function automatic logic sext_ok(input logic [63:0] v, input int unsigned msb);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = 0; i < 64; i++)
      if (i >= msb && v[i] != v[63]) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/rv_instr_encoder.sv
// Combinational encoder: decoded fields + immediate -> 32-bit instruction word.
module rv_instr_encoder
  import rv_loader_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic        funct7,
  input  logic [63:0] imm,
  output logic [31:0] word,
  output logic        imm_err,
  output logic        opc_err
);

  always_comb begin
    word    = '0;
    imm_err = 1'b0;
    opc_err = 1'b0;
    case (opcode)
      OP_R:
        word = {1'b0, funct7, 5'b0, rs2, rs1, funct3, rd, opcode};
      OP_LOAD, OP_IMM, OP_JALR: begin
        word    = {imm[11:0], rs1, funct3, rd, opcode};
        imm_err = !sext_ok(imm, 11);
      end
      OP_STORE: begin
        word    = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        imm_err = !sext_ok(imm, 11);
      end
      // Branch field is imm>>>2, so f[k] is taken straight from imm[k+2].
      OP_BRANCH: begin
        word    = {imm[13], imm[11:6], rs2, rs1, funct3, imm[5:2], imm[12], opcode};
        imm_err = (imm[1:0] != 2'b00) || !sext_ok(imm, 13);
      end
      // JAL field is imm>>>1, so f[k] is imm[k+1].
      OP_JAL: begin
        word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        imm_err = imm[0] || !sext_ok(imm, 20);
      end
      OP_AUIPC: begin
        word    = {imm[31:12], rd, opcode};
        imm_err = (imm[11:0] != 12'h000) || !sext_ok(imm, 31);
      end
      default:
        opc_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Streams decoded instruction fields into consecutive instruction memory words,
// holding the CPU while a load session is active.
module instr_mem_loader
  import rv_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic              funct7,
  input  logic [63:0]       imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic              cpu_hold,
  output logic              done,
  output logic [1:0]        err,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];

  state_t          state, state_nxt;
  logic [31:0]     enc_word;
  logic            imm_err, opc_err;
  logic            last_q;
  logic [ADDR_W:0] count_inc;

  assign count_inc = count + 1'b1;

  rv_instr_encoder u_enc (
    .opcode  (opcode),
    .rd      (rd),
    .rs1     (rs1),
    .rs2     (rs2),
    .funct3  (funct3),
    .funct7  (funct7),
    .imm     (imm),
    .word    (enc_word),
    .imm_err (imm_err),
    .opc_err (opc_err)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    mem_we    = 1'b0;
    done      = 1'b0;
    cpu_hold  = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = LOAD;
      LOAD: begin
        in_ready = 1'b1;
        cpu_hold = 1'b1;
        if (in_valid) state_nxt = (imm_err || opc_err) ? DONE : WRITE;
      end
      WRITE: begin
        // Gated by reset so a reset landing in this cycle never raises we.
        mem_we    = reset_n;
        cpu_hold  = 1'b1;
        state_nxt = (last_q || count_inc == DEPTH_C) ? DONE : LOAD;
      end
      DONE: begin
        done     = 1'b1;
        cpu_hold = (err != ERR_NONE);
        if (start) state_nxt = LOAD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count    <= '0;
      err      <= ERR_NONE;
      mem_din  <= '0;
      mem_addr <= '0;
      last_q   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE:
          if (start) begin
            count <= '0;
            err   <= ERR_NONE;
          end
        LOAD:
          if (in_valid) begin
            if (opc_err)      err <= ERR_OPC;
            else if (imm_err) err <= ERR_IMM;
            else begin
              mem_din  <= enc_word;
              mem_addr <= count[ADDR_W-1:0];
              last_q   <= in_last;
            end
          end
        WRITE: begin
          count <= count_inc;
          if (!last_q && count_inc == DEPTH_C) err <= ERR_OVF;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
Writer-side counterpart of the instruction fetch/decode path (PC, IR, imm_generator). It accepts decoded instruction fields over a valid/ready stream and encodes each one into a 32-bit instruction word, inverting imm_generator's field scrambling and shifts. It writes the words to consecutive addresses of the instruction memory, and holds the CPU while loading. It sits between the testbench or boot source and the instruction memory write port, beside Mux5.

Parameters:
ADDR_W, 5, instruction memory address width
DEPTH, 32, number of writable words; DEPTH ≤ 2**ADDR_W

Ports:
clock  in  1  system clock; all logic on posedge
reset_n  in  1  synchronous, active-low reset
start  in  1  begin a load session at address 0 (sampled in IDLE or DONE)
in_valid  in  1  instruction fields valid
in_ready  out  1  loader accepts fields this cycle
in_last  in  1  accompanying word is the final one
opcode  in  7  RV opcode
rd  in  5  destination register
rs1  in  5  source register 1
rs2  in  5  source register 2
funct3  in  3  funct3
funct7  in  1  instruction bit 30 (ADD=0 / SUB=1)
imm  in  64  signed immediate, byte offset, not pre-shifted
mem_we  out  1  instruction memory write strobe, one-cycle pulse
mem_addr  out  ADDR_W  write address (word index)
mem_din  out  32  encoded instruction word
cpu_hold  out  1  keep PC/IR stalled
done  out  1  session finished (ok or error)
err  out  2  00 ok, 01 immediate out of range/misaligned, 10 unsupported opcode, 11 overflow
count  out  ADDR_W+1  words written this session

Behaviour:
- Reset: all outputs 0 (mem_we=0, in_ready=0, cpu_hold=0, done=0, err=00, count=0). State IDLE. Reset asserted mid-session cancels at the next edge. No write completes after that edge, and no further mem_we pulse occurs.
- FSM states and transitions:
  - IDLE: start → LOAD. Set count=0, err=00, done=0, cpu_hold=1.
  - LOAD: in_ready=1 when no write is pending. A transfer occurs when in_valid & in_ready at a posedge. On a transfer the encoder output is registered into mem_din/mem_addr=count. The next cycle enters WRITE with mem_we=1 and in_ready=0. Throughput is 1 word per 2 cycles. The memory writes on the rising edge of we, so mem_we must return low between words. mem_we is never high two consecutive cycles.
  - WRITE: mem_we=1 for exactly one cycle, then count++. If the word had in_last → DONE. Else, if count reaches DEPTH → DONE with err=11. Otherwise → LOAD.
  - DONE: done=1, in_ready=0. cpu_hold=0 if err=00, otherwise 1. start → LOAD with the same clearing as from IDLE.
- Encode error detected at transfer: no WRITE, word not written, count unchanged → DONE with err set. Error priority: 10 over 01.
- Encoding by opcode; all fields placed at the IR bit positions:
  - 0110011 R: {1'b0,funct7,5'b0,rs2,rs1,funct3,rd,opcode}. imm ignored.
  - 0000011 LOAD, 0010011 ADDI, 1100111 JALR (I-type): {imm[11:0],rs1,funct3,rd,opcode}. imm must lie in −2048..2047.
  - 0100011 S: {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}. Same range as I-type.
  - 1100011 B: f=imm>>>2, 12 bits; imm[1:0] must be 00 and f must lie in −2048..2047. Word bit31=f[11], bit7=f[10], [30:25]=f[9:4], [11:8]=f[3:0].
  - 1101111 JAL: f=imm>>>1, 20 bits; imm[0] must be 0 and f must fit signed 20 bits. [31]=f[19], [19:12]=f[18:11], [20]=f[10], [30:21]=f[9:0].
  - 0010111 AUIPC: imm[11:0] must be 0 and imm>>>12 must fit signed 20 bits. [31:12]=imm[31:12].
  - Any other opcode → err=10.
- All range checks use the full 64-bit signed imm.
- in_valid while not in LOAD is ignored; no transfer occurs.
- start while in LOAD or WRITE is ignored.
- in_last on a word that errors still ends the session with that error.

Decomposition:
- Shared package rv_loader_pkg holds:
  - opcode constants OP_R, OP_LOAD, OP_IMM, OP_JALR, OP_STORE, OP_BRANCH, OP_JAL, OP_AUIPC
  - err codes ERR_NONE, ERR_IMM, ERR_OPC, ERR_OVF
  - state enum IDLE/LOAD/WRITE/DONE
- One combinational sub-module, rv_instr_encoder: fields + imm → word[31:0], imm_err, opc_err.
- The top module holds the FSM, counter and registers.

Test Plan:
- ADD x3,x1,x2 (funct7=0) then SUB x4,x1,x2 (funct7=1, in_last) → mem_din 0x002081B3 @addr0, 0x40208233 @addr1. mem_we pulses are separated by a low cycle; count=2, done=1, err=00, cpu_hold falls to 0.
- ADDI x2,x0,imm=−1 → 0xFFF00113; imm=2048 → err=01, no mem_we, cpu_hold stays 1.
- BEQ rs1=1 rs2=2 imm=8 → 0x00208263; imm=6 (misaligned) → err=01; opcode 0000000 → err=10.
- in_valid held high across 3 words, last on the third → in_ready low in each mem_we cycle. Addresses 0,1,2; exactly 3 mem_we pulses, none consecutive.
- DEPTH=4, 5 words with no last → 4 writes, err=11, done=1, 5th word never accepted.
- reset_n=0 one cycle after the 2nd transfer → no 2nd mem_we pulse, state IDLE, count=0. A following start rewrites from addr 0.
